// File: rtl/seq_alu_n.sv
// seq_alu_n: registered N-bit ALU with a start/busy/done handshake.
// Single-cycle ops (add/sub/and/or/nor) pass through EXEC1. Multi-cycle ops
// (mul/div/rem) run one bit per clock in ITER. Results and status flags are
// committed together on the edge that raises done, and are held until the
// next done.
module seq_alu_n #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N:0]   res,
    output logic         zero,
    output logic         ovf,
    output logic         dz
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_END = CW'(N);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC1 = 2'd1,
        S_ITER  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         state_q;
    logic [2:0]     op_q;
    logic [N-1:0]   a_q;
    logic [N-1:0]   b_q;
    // hi/lo form a shared 2N-bit working register:
    // mul: hi = partial product, lo = multiplier shifting out (product low half)
    // div: hi = partial remainder, lo = dividend shifting out / quotient in
    logic [N-1:0]   hi_q, hi_d;
    logic [N-1:0]   lo_q, lo_d;
    logic [CW-1:0]  cnt_q;
    logic [N:0]     stage_res_q;
    logic           stage_ovf_q;
    logic           stage_dz_q;
    logic           busy_q, done_q, zero_q, ovf_q, dz_q;
    logic [N:0]     res_q;

    logic [N:0]     sum_w, diff_w;
    logic [N:0]     alu_res;
    logic           alu_ovf;
    logic [N-1:0]   bw;
    logic [N:0]     mul_sum;
    logic [N:0]     div_shift;
    logic           div_ge;
    logic [N-1:0]   div_sub;
    logic [N:0]     iter_res;

    assign sum_w  = {1'b0, a_q} + {1'b0, b_q};
    assign diff_w = {1'b0, a_q} - {1'b0, b_q};

    // Single-cycle ALU result and signed-overflow flag from latched operands
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        bw      = '0;
        case (op_q)
            3'b000: begin
                alu_res = sum_w;
                alu_ovf = (a_q[N-1] == b_q[N-1]) && (sum_w[N-1] != a_q[N-1]);
            end
            3'b001: begin
                alu_res = diff_w;
                alu_ovf = (a_q[N-1] != b_q[N-1]) && (diff_w[N-1] != a_q[N-1]);
            end
            3'b010: begin
                bw      = a_q & b_q;
                alu_res = {bw[N-1], bw};
            end
            3'b011: begin
                bw      = a_q | b_q;
                alu_res = {bw[N-1], bw};
            end
            3'b100: begin
                bw      = ~(a_q | b_q);
                alu_res = {bw[N-1], bw};
            end
            default: begin
                alu_res = '0;
                alu_ovf = 1'b0;
            end
        endcase
    end

    // Shift-add step: add A when the current multiplier bit is set, then shift right
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(N+1){1'b0}});

    // Restoring step: shift next dividend bit in, subtract B only if it fits.
    // When it does not fit the shifted value is below B, so its top bit is 0.
    assign div_shift = {hi_q, lo_q[N-1]};
    assign div_ge    = (div_shift >= {1'b0, b_q});
    assign div_sub   = div_shift[N-1:0] - b_q;

    // Next value of the working register for one iteration
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (op_q == 3'b101) begin
            hi_d = mul_sum[N:1];
            lo_d = {mul_sum[0], lo_q[N-1:1]};
        end else begin
            hi_d = div_ge ? div_sub : div_shift[N-1:0];
            lo_d = {lo_q[N-2:0], div_ge};
        end
    end

    // Final multi-cycle result selected from the working register
    always_comb begin
        iter_res = '0;
        case (op_q)
            3'b101:  iter_res = {|hi_q, lo_q};
            3'b110:  iter_res = {1'b0, lo_q};
            default: iter_res = {1'b0, hi_q};
        endcase
    end

    // Control FSM with registered handshake outputs and result/flag commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            cnt_q       <= '0;
            stage_res_q <= '0;
            stage_ovf_q <= 1'b0;
            stage_dz_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_q       <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q    <= op;
                        a_q     <= a;
                        b_q     <= b;
                        hi_q    <= '0;
                        lo_q    <= (op == 3'b101) ? b : a;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= (op <= 3'b100) ? S_EXEC1 : S_ITER;
                    end
                end
                S_EXEC1: begin
                    stage_res_q <= alu_res;
                    stage_ovf_q <= alu_ovf;
                    stage_dz_q  <= 1'b0;
                    state_q     <= S_DONE;
                end
                S_ITER: begin
                    // Counts 0..N-1 perform the bit steps; the cycle after the
                    // last step captures the finished result.
                    if (cnt_q == CNT_END) begin
                        stage_res_q <= iter_res;
                        stage_ovf_q <= 1'b0;
                        stage_dz_q  <= (op_q != 3'b101) && (b_q == '0);
                        state_q     <= S_DONE;
                    end else begin
                        hi_q  <= hi_d;
                        lo_q  <= lo_d;
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_DONE: begin
                    res_q   <= stage_res_q;
                    zero_q  <= (stage_res_q[N-1:0] == '0);
                    ovf_q   <= stage_ovf_q;
                    dz_q    <= stage_dz_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign res  = res_q;
    assign zero = zero_q;
    assign ovf  = ovf_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_seq_alu_n.sv
// Testbench for seq_alu_n: one N=32 and one N=8 instance, a directed vector
// table, randomized ops against an arithmetic reference model, and
// hand-written handshake / reset sequences.
module tb_seq_alu_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start32, start8;
    logic [2:0]  op32, op8;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;
    logic        busy32, done32, zero32, ovf32, dz32;
    logic        busy8, done8, zero8, ovf8, dz8;
    logic [32:0] res32;
    logic [8:0]  res8;

    seq_alu_n #(.N(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .op(op32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .res(res32), .zero(zero32), .ovf(ovf32), .dz(dz32)
    );

    seq_alu_n #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .res(res8), .zero(zero8), .ovf(ovf8), .dz(dz8)
    );

    int total = 0;
    int bad   = 0;
    int sel_w = 8;

    logic        busy_m, done_m;
    logic [64:0] res_m;
    logic [2:0]  flg_m;   // {zero, ovf, dz}

    always_comb begin
        busy_m = busy8;
        done_m = done8;
        res_m  = {56'd0, res8};
        flg_m  = {zero8, ovf8, dz8};
        if (sel_w == 32) begin
            busy_m = busy32;
            done_m = done32;
            res_m  = {32'd0, res32};
            flg_m  = {zero32, ovf32, dz32};
        end
    end

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: {res[64:0], zero, ovf, dz} from plain arithmetic.
    function automatic logic [67:0] model(input int w, input logic [2:0] o,
                                          input logic [63:0] av, input logic [63:0] bv);
        logic [63:0] mask, t, p;
        logic [64:0] r;
        logic        ovf_m, dz_m, z_m;
        longint      sa, sb, s, lim;
        mask  = (64'd1 << w) - 64'd1;
        lim   = longint'(64'd1 << (w - 1));
        sa    = av[w-1] ? longint'(av) - 2 * lim : longint'(av);
        sb    = bv[w-1] ? longint'(bv) - 2 * lim : longint'(bv);
        r     = '0;
        t     = '0;
        p     = '0;
        s     = 0;
        ovf_m = 1'b0;
        dz_m  = 1'b0;
        case (o)
            3'd0: begin r = {1'b0, av} + {1'b0, bv}; s = sa + sb; ovf_m = (s < -lim) || (s >= lim); end
            3'd1: begin r = {1'b0, av} - {1'b0, bv}; s = sa - sb; ovf_m = (s < -lim) || (s >= lim); end
            3'd2, 3'd3, 3'd4: begin
                if (o == 3'd2)      t = av & bv;
                else if (o == 3'd3) t = av | bv;
                else                t = ~(av | bv) & mask;
                r = {1'b0, t} | (t[w-1] ? (65'd1 << w) : 65'd0);
            end
            3'd5: begin
                p = av * bv;
                r = {1'b0, p & mask} | (((p >> w) != 64'd0) ? (65'd1 << w) : 65'd0);
            end
            3'd6: begin dz_m = (bv == 64'd0); r = dz_m ? {1'b0, mask} : {1'b0, av / bv}; end
            default: begin dz_m = (bv == 64'd0); r = dz_m ? {1'b0, av} : {1'b0, av % bv}; end
        endcase
        r   = r & ((65'd1 << (w + 1)) - 65'd1);
        z_m = ((r[63:0] & mask) == 64'd0);
        return {r, z_m, ovf_m, dz_m};
    endfunction

    task automatic launch(input int w, input logic [2:0] o, input logic [63:0] av, input logic [63:0] bv);
        sel_w = w;
        if (w == 32) begin start32 = 1'b1; op32 = o; a32 = av[31:0]; b32 = bv[31:0]; end
        else         begin start8  = 1'b1; op8  = o; a8  = av[7:0];  b8  = bv[7:0];  end
    endtask

    // Waits from the accepting edge until done; optionally pulses start while busy.
    task automatic wait_done(input bit noise, output int lat, output int bcnt, output bit held);
        logic [64:0] prev;
        @(posedge clk); #1;
        start32 = 1'b0; start8 = 1'b0;
        a32 = $urandom; b32 = $urandom; a8 = 8'($urandom); b8 = 8'($urandom);
        op32 = 3'($urandom); op8 = 3'($urandom);
        lat = 0; held = 1'b1; prev = res_m;
        bcnt = busy_m ? 1 : 0;
        while (1) begin
            @(posedge clk); #1;
            lat++;
            if (done_m) break;
            if (busy_m) bcnt++;
            if (res_m !== prev) held = 1'b0;
            if (lat > 200) break;
            if (noise) begin
                start32 = (sel_w == 32) ? 1'($urandom) : 1'b0;
                start8  = (sel_w == 8)  ? 1'($urandom) : 1'b0;
                op32 = 3'd0; op8 = 3'd0; a32 = 32'd1; b32 = 32'd1; a8 = 8'd1; b8 = 8'd1;
            end
        end
        start32 = 1'b0; start8 = 1'b0;
    endtask

    task automatic check_op(input string name, input int w, input logic [2:0] o,
                            input logic [64:0] er, input logic [2:0] ef,
                            input int lat, input int bcnt, input bit held);
        int exp_lat;
        exp_lat = (o <= 3'd4) ? 2 : w + 2;
        $display("op w=%0d op=%0d res=0x%0h flags=%b lat=%0d", w, o, res_m, flg_m, lat);
        chk({name, " res"},   res_m, er);
        chk({name, " flags"}, {62'd0, flg_m}, {62'd0, ef});
        chk({name, " lat"},   65'(lat), 65'(exp_lat));
        chk({name, " busy"},  65'(bcnt), 65'(exp_lat));
        chk({name, " hold"},  {64'd0, held}, 65'd1);
    endtask

    task automatic do_op(input string name, input int w, input logic [2:0] o,
                         input logic [63:0] av, input logic [63:0] bv,
                         input logic [64:0] er, input logic [2:0] ef, input bit noise);
        int lat, bcnt;
        bit held;
        @(negedge clk);
        launch(w, o, av, bv);
        wait_done(noise, lat, bcnt, held);
        check_op(name, w, o, er, ef, lat, bcnt, held);
    endtask

    typedef struct {
        int          w;
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [64:0] res;
        logic [2:0]  flg;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int lat, bcnt;
        bit held;
        logic [67:0] m;
        logic [63:0] av, bv, mask;
        logic [2:0]  o;
        int w;

        tbl[0]  = '{32, 3'd0, 64'hFFFF_FFFF, 64'h1,  65'h1_0000_0000, 3'b100};
        tbl[1]  = '{32, 3'd1, 64'h8000_0000, 64'h1,  65'h0_7FFF_FFFF, 3'b010};
        tbl[2]  = '{32, 3'd1, 64'h3,         64'h5,  65'h1_FFFF_FFFE, 3'b000};
        tbl[3]  = '{32, 3'd0, 64'h7FFF_FFFF, 64'h1,  65'h0_8000_0000, 3'b010};
        tbl[4]  = '{8,  3'd5, 64'h10,        64'h11, 65'h110,         3'b000};
        tbl[5]  = '{8,  3'd5, 64'h0F,        64'h03, 65'h02D,         3'b000};
        tbl[6]  = '{8,  3'd6, 64'hC8,        64'h07, 65'h01C,         3'b000};
        tbl[7]  = '{8,  3'd7, 64'hC8,        64'h07, 65'h004,         3'b000};
        tbl[8]  = '{8,  3'd6, 64'h09,        64'h00, 65'h0FF,         3'b001};
        tbl[9]  = '{8,  3'd7, 64'h09,        64'h00, 65'h009,         3'b001};
        tbl[10] = '{8,  3'd2, 64'hF0,        64'h0F, 65'h000,         3'b100};
        tbl[11] = '{8,  3'd3, 64'h80,        64'h01, 65'h181,         3'b000};
        tbl[12] = '{8,  3'd4, 64'h0F,        64'hF0, 65'h000,         3'b100};
        tbl[13] = '{32, 3'd7, 64'hFFFF_FFFF, 64'h10, 65'h00F,         3'b000};

        rst = 1'b1;
        start32 = 1'b0; start8 = 1'b0;
        op32 = '0; op8 = '0; a32 = '0; b32 = '0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy/done", {61'd0, busy32, done32, busy8, done8}, 65'd0);
        chk("reset res32", {32'd0, res32}, 65'd0);
        chk("reset res8", {56'd0, res8}, 65'd0);
        chk("reset flags", {59'd0, zero32, ovf32, dz32, zero8, ovf8, dz8}, 65'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < 14; i++) begin
            do_op($sformatf("vec%0d", i), tbl[i].w, tbl[i].op, tbl[i].a, tbl[i].b,
                  tbl[i].res, tbl[i].flg, 1'b0);
        end

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            w    = (i % 2 == 0) ? 8 : 32;
            mask = (64'd1 << w) - 64'd1;
            o    = 3'($urandom);
            av   = {32'd0, $urandom} & mask;
            bv   = ($urandom_range(0, 7) == 0) ? 64'd0 : ({32'd0, $urandom} & mask);
            m    = model(w, o, av, bv);
            do_op($sformatf("rnd%0d", i), w, o, av, bv, m[67:3], m[2:0], 1'b0);
        end

        // Start pulses during the iteration are ignored
        do_op("ignore-start", 8, 3'd5, 64'h10, 64'h11, 65'h110, 3'b000, 1'b1);

        // Start in the done cycle is accepted
        @(negedge clk);
        launch(8, 3'd6, 64'd200, 64'd7);
        wait_done(1'b0, lat, bcnt, held);
        check_op("chain-div", 8, 3'd6, 65'h01C, 3'b000, lat, bcnt, held);
        launch(8, 3'd4, 64'd0, 64'd0);
        wait_done(1'b0, lat, bcnt, held);
        check_op("chain-nor", 8, 3'd4, 65'h1FF, 3'b000, lat, bcnt, held);

        // Asynchronous reset in the middle of a multiply
        @(negedge clk);
        launch(8, 3'd5, 64'h10, 64'h11);
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("pre-reset busy", {64'd0, busy8}, 65'd1);
        rst = 1'b1;
        #1;
        chk("async busy/done", {63'd0, busy8, done8}, 65'd0);
        chk("async res", {56'd0, res8}, 65'd0);
        chk("async flags", {62'd0, zero8, ovf8, dz8}, 65'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op("post-reset add", 8, 3'd0, 64'd2, 64'd2, 65'h004, 3'b000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
